// File: rtl/toggle_decoder_if.sv
// Bundle of the toggle decoder's control inputs and status outputs.
// The master side drives en/t_in/ack/clr_cnt; the slave (the decoder) drives the status.
interface toggle_decoder_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             t_in;
  logic             ack;
  logic             clr_cnt;
  logic             pulse;
  logic             q_ref;
  logic             pending;
  logic             ovf;
  logic [CNT_W-1:0] evt_cnt;

  modport master (
    output en, t_in, ack, clr_cnt,
    input  pulse, q_ref, pending, ovf, evt_cnt
  );

  modport slave (
    input  en, t_in, ack, clr_cnt,
    output pulse, q_ref, pending, ovf, evt_cnt
  );
endinterface

// File: rtl/toggle_decoder.sv
// Receive-side decoder for toggle-encoded events: synchroniser, change detect, pending/ack and counter.
// Define TOGGLE_DECODER_SAT_EN to make evt_cnt saturate at all-ones instead of wrapping.
module toggle_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input logic           clk,
  input logic           rst,
  toggle_decoder_if.slave bus
);

  typedef enum logic {IDLE, HELD} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   q_ref;
  logic                   chg;
  logic                   evt;
  logic                   pulse;
  logic                   ovf;
  logic                   ovf_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;

  assign s   = sync[SYNC_STAGES-1];
  assign chg = s ^ q_ref;
  assign evt = bus.en & chg;

  // q_ref tracks s even while disabled, so re-enabling never produces a stale event
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      q_ref <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], bus.t_in};
      q_ref <= s;
      pulse <= evt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;

    case (state)
      IDLE: begin
        if (evt) state_nxt = HELD;
      end
      HELD: begin
        // A new event in the same cycle as ack simply replaces the acked one
        if (evt) begin
          if (!bus.ack) ovf_nxt = 1'b1;
        end else if (bus.ack) begin
          state_nxt = IDLE;
        end
      end
    endcase

`ifdef TOGGLE_DECODER_SAT_EN
    if (evt && (cnt != {CNT_W{1'b1}})) cnt_nxt = cnt + 1'b1;
`else
    if (evt) cnt_nxt = cnt + 1'b1;
`endif

    // Clear wins over a coincident overflow but still counts the coincident event
    if (bus.clr_cnt) begin
      ovf_nxt = 1'b0;
      cnt_nxt = CNT_W'(evt);
    end
  end

  assign bus.pulse   = pulse;
  assign bus.q_ref   = q_ref;
  assign bus.pending = (state == HELD);
  assign bus.ovf     = ovf;
  assign bus.evt_cnt = cnt;

endmodule

// File: tb/tb_toggle_decoder.sv
// Self-checking bench for toggle_decoder: directed scenarios plus randomized traffic against an event-level model.
// The model schedules one event SYNC_STAGES edges after each observed t_in change; reset drops the schedule.
module tb_toggle_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  toggle_decoder_if #(.CNT_W(CNT_W)) bus ();

  toggle_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   at;
    logic lvl;
  } due_t;

  due_t due_q[$];
  int   cyc       = 0;
  int   m_count   = 0;
  logic m_last    = 1'b0;
  logic m_qref    = 1'b0;
  logic m_pulse   = 1'b0;
  logic m_pending = 1'b0;
  logic m_ovf     = 1'b0;

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef TOGGLE_DECODER_SAT_EN
    return (m_count > (1 << CNT_W) - 1) ? {CNT_W{1'b1}} : CNT_W'(m_count);
`else
    return CNT_W'(m_count % (1 << CNT_W));
`endif
  endfunction

  // One clock edge: advance the event-level model with the inputs held across the edge
  task automatic step();
    logic hit;
    logic ev;
    due_t d;
    @(posedge clk);
    cyc++;
    hit = 1'b0;
    if (rst) begin
      due_q.delete();
      m_last    = 1'b0;
      m_qref    = 1'b0;
      m_pulse   = 1'b0;
      m_pending = 1'b0;
      m_ovf     = 1'b0;
      m_count   = 0;
    end else begin
      if (due_q.size() > 0 && due_q[0].at == cyc) begin
        hit    = 1'b1;
        m_qref = due_q[0].lvl;
        void'(due_q.pop_front());
      end
      ev = hit & bus.en;
      if (bus.t_in != m_last) begin
        d.at  = cyc + SYNC_STAGES;
        d.lvl = bus.t_in;
        due_q.push_back(d);
        m_last = bus.t_in;
      end
      m_pulse = ev;
      if (ev && m_pending && !bus.ack) m_ovf = 1'b1;
      if (bus.clr_cnt) m_ovf = 1'b0;
      if (ev) m_pending = 1'b1;
      else if (bus.ack) m_pending = 1'b0;
      if (bus.clr_cnt) m_count = ev ? 1 : 0;
      else if (ev) m_count++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.t_in = 1'b0; bus.ack = 1'b0; bus.clr_cnt = 1'b0;
    step();
    step();
    tests++; if (bus.pulse !== 1'b0) begin fails++; $display("[TB] FAIL reset_pulse: got %b want 0", bus.pulse); end
    tests++; if (bus.q_ref !== 1'b0) begin fails++; $display("[TB] FAIL reset_q_ref: got %b want 0", bus.q_ref); end
    tests++; if (bus.pending !== 1'b0) begin fails++; $display("[TB] FAIL reset_pending: got %b want 0", bus.pending); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf: got %b want 0", bus.ovf); end
    tests++; if (bus.evt_cnt !== 4'h0) begin fails++; $display("[TB] FAIL reset_evt_cnt: got %h want 0", bus.evt_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_single_toggle();
    step();
    step();
    bus.t_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (bus.pulse !== (i == 3)) begin
        fails++; $display("[TB] FAIL single_pulse_edge%0d: got %b want %b", i, bus.pulse, (i == 3));
      end
    end
    tests++; if (bus.q_ref !== 1'b1) begin fails++; $display("[TB] FAIL single_q_ref: got %b want 1", bus.q_ref); end
    tests++; if (bus.pending !== 1'b1) begin fails++; $display("[TB] FAIL single_pending: got %b want 1", bus.pending); end
    tests++; if (bus.evt_cnt !== 4'h1) begin fails++; $display("[TB] FAIL single_evt_cnt: got %h want 1", bus.evt_cnt); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    tests++; if (bus.pending !== 1'b0) begin fails++; $display("[TB] FAIL single_ack_pending: got %b want 0", bus.pending); end
  endtask

  task automatic test_disabled();
    bus.clr_cnt = 1'b1;
    step();
    bus.clr_cnt = 1'b0;
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.t_in = ~bus.t_in;
      for (int j = 0; j < 4; j++) begin
        step();
        tests++; if (bus.pulse !== 1'b0) begin fails++; $display("[TB] FAIL dis_pulse: got %b want 0", bus.pulse); end
        tests++; if (bus.q_ref !== m_qref) begin fails++; $display("[TB] FAIL dis_q_ref: got %b want %b", bus.q_ref, m_qref); end
      end
      tests++; if (bus.q_ref !== bus.t_in) begin fails++; $display("[TB] FAIL dis_follow: got %b want %b", bus.q_ref, bus.t_in); end
    end
    bus.en = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      tests++; if (bus.pulse !== 1'b0) begin fails++; $display("[TB] FAIL reenable_pulse: got %b want 0", bus.pulse); end
    end
    tests++; if (bus.evt_cnt !== 4'h0) begin fails++; $display("[TB] FAIL dis_evt_cnt: got %h want 0", bus.evt_cnt); end
    tests++; if (bus.pending !== 1'b0) begin fails++; $display("[TB] FAIL dis_pending: got %b want 0", bus.pending); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      bus.t_in = ~bus.t_in;
      repeat (4) step();
    end
    tests++; if (bus.pending !== 1'b1) begin fails++; $display("[TB] FAIL ovf_pending: got %b want 1", bus.pending); end
    tests++; if (bus.ovf !== 1'b1) begin fails++; $display("[TB] FAIL ovf_set: got %b want 1", bus.ovf); end
    tests++; if (bus.evt_cnt !== 4'h2) begin fails++; $display("[TB] FAIL ovf_evt_cnt: got %h want 2", bus.evt_cnt); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    tests++; if (bus.pending !== 1'b0) begin fails++; $display("[TB] FAIL ovf_ack_pending: got %b want 0", bus.pending); end
    tests++; if (bus.ovf !== 1'b1) begin fails++; $display("[TB] FAIL ovf_sticky: got %b want 1", bus.ovf); end
    bus.clr_cnt = 1'b1;
    step();
    bus.clr_cnt = 1'b0;
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("[TB] FAIL ovf_clr: got %b want 0", bus.ovf); end
    tests++; if (bus.evt_cnt !== 4'h0) begin fails++; $display("[TB] FAIL ovf_clr_cnt: got %h want 0", bus.evt_cnt); end
  endtask

  task automatic test_event_with_ack();
    bus.t_in = ~bus.t_in;
    repeat (4) step();
    tests++; if (bus.pending !== 1'b1) begin fails++; $display("[TB] FAIL ea_first_pending: got %b want 1", bus.pending); end
    bus.t_in = ~bus.t_in;
    step();
    step();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    tests++; if (bus.pulse !== 1'b1) begin fails++; $display("[TB] FAIL ea_pulse: got %b want 1", bus.pulse); end
    tests++; if (bus.pending !== 1'b1) begin fails++; $display("[TB] FAIL ea_pending: got %b want 1", bus.pending); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("[TB] FAIL ea_ovf: got %b want 0", bus.ovf); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic test_rollover();
    logic [CNT_W-1:0] want;
    bus.clr_cnt = 1'b1;
    step();
    bus.clr_cnt = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.t_in = ~bus.t_in;
      repeat (4) step();
      tests++; if (bus.evt_cnt !== exp_cnt()) begin fails++; $display("[TB] FAIL roll_step%0d: got %h want %h", i, bus.evt_cnt, exp_cnt()); end
    end
`ifdef TOGGLE_DECODER_SAT_EN
    want = 4'hF;
`else
    want = 4'h1;
`endif
    tests++; if (bus.evt_cnt !== want) begin fails++; $display("[TB] FAIL roll_final: got %h want %h", bus.evt_cnt, want); end
  endtask

  task automatic test_reset_midflight();
    if (bus.t_in) begin
      bus.t_in = 1'b0;
      repeat (4) step();
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    bus.t_in = 1'b1;
    step();
    tests++; if (bus.pulse !== 1'b0) begin fails++; $display("[TB] FAIL mid_pre_pulse: got %b want 0", bus.pulse); end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (bus.pulse !== 1'b0) begin fails++; $display("[TB] FAIL mid_pulse: got %b want 0", bus.pulse); end
      tests++; if (bus.evt_cnt !== 4'h0) begin fails++; $display("[TB] FAIL mid_evt_cnt: got %h want 0", bus.evt_cnt); end
    end
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (bus.pulse !== (i == 3)) begin
        fails++; $display("[TB] FAIL mid_release_edge%0d: got %b want %b", i, bus.pulse, (i == 3));
      end
    end
    tests++; if (bus.evt_cnt !== 4'h1) begin fails++; $display("[TB] FAIL mid_release_cnt: got %h want 1", bus.evt_cnt); end
  endtask

  task automatic test_random();
    int gap;
    gap = 0;
    for (int n = 0; n < 800; n++) begin
      if (gap == 0) begin
        bus.t_in = ~bus.t_in;
        gap = $urandom_range(2, 6);
      end else begin
        gap--;
      end
      if ($urandom_range(0, 9) == 0) bus.en = ~bus.en;
      bus.ack     = ($urandom_range(0, 2) == 0);
      bus.clr_cnt = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      step();
      tests++; if (bus.pulse !== m_pulse) begin fails++; $display("[TB] FAIL rnd_pulse@%0d: got %b want %b", cyc, bus.pulse, m_pulse); end
      tests++; if (bus.q_ref !== m_qref) begin fails++; $display("[TB] FAIL rnd_q_ref@%0d: got %b want %b", cyc, bus.q_ref, m_qref); end
      tests++; if (bus.pending !== m_pending) begin fails++; $display("[TB] FAIL rnd_pending@%0d: got %b want %b", cyc, bus.pending, m_pending); end
      tests++; if (bus.ovf !== m_ovf) begin fails++; $display("[TB] FAIL rnd_ovf@%0d: got %b want %b", cyc, bus.ovf, m_ovf); end
      tests++; if (bus.evt_cnt !== exp_cnt()) begin fails++; $display("[TB] FAIL rnd_evt_cnt@%0d: got %h want %h", cyc, bus.evt_cnt, exp_cnt()); end
    end
    rst = 1'b0;
    bus.ack = 1'b0;
    bus.clr_cnt = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.t_in = 1'b0;
    bus.ack = 1'b0;
    bus.clr_cnt = 1'b0;
    test_reset();
    test_single_toggle();
    test_disabled();
    test_overflow();
    test_event_with_ack();
    test_rollover();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/toggle_decoder.md
Name: toggle_decoder

Overview:
- Receive-side decoder for toggle-encoded event signalling. The transmit end flips a single level (`t_in`) once per event, T-flip-flop style.
- This block synchronises `t_in` and detects each level change. Each change becomes a one-cycle `pulse`.
- Events are counted. A pending/ack handshake holds each event for a downstream consumer, with a sticky overflow flag for events lost while one is pending.

Parameters:
- `SYNC_STAGES`, 2, number of synchroniser flops on `t_in`; legal range 2..4.
- `CNT_W`, 8, width of the event counter.

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous active-high reset
- `en`  input  1  decode enable; when 0, level changes are absorbed without events
- `t_in`  input  1  toggle-encoded event line (asynchronous to `clk`)
- `ack`  input  1  consumer acknowledge; clears `pending`
- `clr_cnt`  input  1  synchronous clear of `evt_cnt` and `ovf`
- `pulse`  output  1  one-cycle strobe per detected toggle
- `q_ref`  output  1  decoder's reconstructed copy of the transmitter level
- `pending`  output  1  event awaiting `ack`
- `ovf`  output  1  sticky: event detected while `pending`=1 and no same-cycle `ack`
- `evt_cnt`  output  `CNT_W`  number of decoded events

Behaviour:
- Reset (`rst`=1 at a rising edge):
  - All sync flops, `q_ref`, `pulse`, `pending` and `ovf` become 0; `evt_cnt` becomes 0.
  - `rst` has priority over every other input.
- Synchroniser:
  - `SYNC_STAGES`-deep shift chain on `t_in`; `s` is the last stage.
  - No logic may sample `t_in` directly.
- Detect:
  - `chg = (s != q_ref)`.
  - Every non-reset edge sets `q_ref <= s`, regardless of `en`.
  - With `en`=0, changes are tracked but produce no pulse, no count and no pending. Re-enabling never yields a stale event.
- Pulse:
  - `pulse <= en & chg`, registered, high for exactly one cycle per toggle.
  - Two toggles separated by at least 1 cycle at `s` give two pulses.
  - Toggles faster than the `clk` period may merge (transmitter contract: at least 2 `clk` periods between toggles).
- Latency: `t_in` changes (meeting setup) before edge E0; `pulse` is high during the cycle after edge E(`SYNC_STAGES`), i.e. `SYNC_STAGES`+1 edges. For the default this is 3 edges.
- Handshake state machine, states IDLE (`pending`=0) and HELD (`pending`=1):
  - IDLE, event: go to HELD.
  - HELD, `ack` with no event: go to IDLE.
  - HELD, event and `ack` in the same cycle: stay HELD, `ovf` unchanged (new event replaces acked one).
  - HELD, event with no `ack`: stay HELD, set `ovf`=1.
  - IDLE, `ack`: ignored.
  - "Event" here means the registered pulse condition (`en & chg`), evaluated on the same edge that sets `pulse`.
- Counter:
  - `evt_cnt` increments by 1 on each event, modulo 2^`CNT_W`.
  - `clr_cnt` zeroes `evt_cnt` and `ovf`. If `clr_cnt` and an event coincide, the result is `evt_cnt`=1 and `ovf` is cleared.
  - `clr_cnt` does not affect `pending` or `q_ref`.
- Reset mid-operation: any in-flight toggle in the sync chain is discarded.
  - After reset release, `q_ref` restarts at 0.
  - If `t_in` is held at 1, one event is decoded `SYNC_STAGES`+1 edges after release, provided `en`=1.
- `ovf` is sticky; it clears only on `rst` or `clr_cnt`.

Optional Feature:
- Macro `TOGGLE_DECODER_SAT_EN`.
- Defined: `evt_cnt` saturates at all-ones; further events still pulse, update `pending` and may set `ovf`, but the count holds.
- Undefined: `evt_cnt` wraps to 0 after all-ones.

Test Plan (`SYNC_STAGES`=2, `CNT_W`=4 unless noted):
- Single toggle, latency and reset behaviour:
  - Stimulus: `rst`=1 for 2 cycles, then `en`=1; `t_in` 0->1.
  - Response: `pulse` high exactly one cycle, 3 edges after the change; `q_ref`=1, `pending`=1, `evt_cnt`=1; all outputs 0 during reset.
- Toggles ignored while disabled:
  - Stimulus: `en`=0, `t_in` toggles 5 times at 4-cycle spacing, then `en`=1 with no further toggles.
  - Response: no pulse, `evt_cnt`=0, `pending`=0, `q_ref` follows `t_in`.
- Overflow handling:
  - Stimulus: two toggles 4 cycles apart with no `ack`.
  - Response: `pending`=1, `ovf`=1, `evt_cnt`=2.
  - Stimulus, continued: `ack` for 1 cycle.
  - Response: `pending`=0, `ovf` stays 1.
  - Stimulus, continued: `clr_cnt`.
  - Response: `ovf`=0, `evt_cnt`=0.
- Event and `ack` in the same cycle: event coinciding with `ack` while HELD gives `pending`=1, `ovf`=0.
- Counter rollover:
  - Stimulus: 17 toggles at 4-cycle spacing.
  - Response: `evt_cnt`=1 when the macro is undefined; `evt_cnt`=15 (4'hF) with `TOGGLE_DECODER_SAT_EN` defined.
- Reset mid-flight: `t_in` toggles, then `rst` asserts 1 edge later; no pulse occurs in the 5 cycles following the change, and `evt_cnt`=0.
